quan_sa_tile_ctrl: RTL

// - Sequencer for one quantised systolic-array tile job.
// - Drives the array control pins: reset, cell_en_pre, cell_output_en_pre, mode_init and mult_array_mode.
// - Gates operand beats from the upstream feeder with a valid/ready handshake.
// - Tags the drained row results with out_valid, out_row and out_last.
// - Handles conv jobs (mode 0 = 8x8, mode 1 = 1x8) and the row-0 multiply pass (mult_array_mode).

---
 rtl/quan_sa_tile_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/quan_sa_tile_ctrl.sv
// quan_sa_tile_ctrl
// Sequencer for one quantised systolic-array tile job. It walks the array
// through configuration, operand loading, wavefront flush, row drain and
// completion. Along the way it drives the array control pins, gates upstream
// operand beats and tags the drained rows.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   start, cfg_mode, cfg_mult, cfg_k_beats
//                              job request and its configuration; sampled only in IDLE
//   busy, done, err_zero_k     job status: done is a 1-cycle end pulse,
//                              err_zero_k pulses when a k=0 request is rejected
//   in_valid, in_ready         operand beat handshake with the upstream feeder
//   sa_*                       array control pins
//   out_valid, out_row, out_last
//                              tags for the drained row results
module quan_sa_tile_ctrl #(
    parameter  int ROWS     = 16,
    parameter  int COLS     = 16,
    parameter  int K_W      = 12,
    parameter  int FILL_LAT = 32,
    parameter  int OUT_LAT  = 3,
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       cfg_mode,
    input  logic             cfg_mult,
    input  logic [K_W-1:0]   cfg_k_beats,
    output logic             busy,
    output logic             done,
    output logic             err_zero_k,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sa_reset,
    output logic             sa_cell_en_pre,
    output logic             sa_cell_output_en_pre,
    output logic [3:0]       sa_mode_init,
    output logic             sa_mult_array_mode,
    output logic             out_valid,
    output logic [ROW_W-1:0] out_row,
    output logic             out_last
);

    // The phase counter serves every timed state, so it must reach the longest of them.
    localparam int PH_MAX = (FILL_LAT > ROWS) ? ((FILL_LAT > COLS) ? FILL_LAT : COLS)
                                              : ((ROWS > COLS) ? ROWS : COLS);
    localparam int PH_TOP = (PH_MAX > OUT_LAT) ? PH_MAX : OUT_LAT;
    localparam int PH_W   = $clog2(PH_TOP + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        LOAD  = 3'd2,
        FLUSH = 3'd3,
        OUT   = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t          state;
    logic [K_W-1:0]  k_r;
    logic [3:0]      mode_r;
    logic            mult_r;
    logic [K_W-1:0]  beat_cnt;
    logic [PH_W-1:0] phase;
    logic            last_en;
    logic [OUT_LAT-1:0] ov_pipe;
    logic [OUT_LAT-1:0] last_pipe;

    // The mult pass only flushes one column wavefront and drains a single row.
    logic [PH_W-1:0] flush_last_s;
    logic [PH_W-1:0] out_last_idx_s;
    assign flush_last_s   = mult_r ? PH_W'(COLS - 1) : PH_W'(FILL_LAT - 1);
    assign out_last_idx_s = mult_r ? {PH_W{1'b0}} : PH_W'(ROWS - 1);

    // A beat enters the array in the same cycle it is accepted, so the enable
    // follows the handshake directly instead of lagging it by a register.
    assign sa_cell_en_pre = in_ready & in_valid;

    assign out_valid = ov_pipe[OUT_LAT-1];
    assign out_last  = last_pipe[OUT_LAT-1];

    // Job sequencer; every output is set on the edge that enters its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            k_r                   <= {K_W{1'b0}};
            mode_r                <= 4'd0;
            mult_r                <= 1'b0;
            beat_cnt              <= {K_W{1'b0}};
            phase                 <= {PH_W{1'b0}};
            busy                  <= 1'b0;
            done                  <= 1'b0;
            err_zero_k            <= 1'b0;
            in_ready              <= 1'b0;
            sa_reset              <= 1'b1;
            sa_cell_output_en_pre <= 1'b0;
            sa_mode_init          <= 4'd0;
            sa_mult_array_mode    <= 1'b0;
            last_en               <= 1'b0;
        end else begin
            done       <= 1'b0;
            err_zero_k <= 1'b0;
            case (state)
                IDLE: begin
                    busy     <= 1'b0;
                    sa_reset <= 1'b0;
                    if (start) begin
                        if (cfg_k_beats != {K_W{1'b0}}) begin
                            state              <= CFG;
                            k_r                <= cfg_k_beats;
                            mode_r             <= cfg_mode;
                            mult_r             <= cfg_mult;
                            beat_cnt           <= {K_W{1'b0}};
                            phase              <= {PH_W{1'b0}};
                            busy               <= 1'b1;
                            sa_reset           <= 1'b1;
                            sa_mode_init       <= cfg_mode;
                            sa_mult_array_mode <= cfg_mult;
                        end else begin
                            err_zero_k <= 1'b1;
                        end
                    end
                end
                CFG: begin
                    if (phase == PH_W'(1)) begin
                        state        <= LOAD;
                        phase        <= {PH_W{1'b0}};
                        sa_reset     <= 1'b0;
                        sa_mode_init <= 4'd0;
                        in_ready     <= 1'b1;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (beat_cnt == k_r - K_W'(1)) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                            phase    <= {PH_W{1'b0}};
                        end else begin
                            beat_cnt <= beat_cnt + K_W'(1);
                        end
                    end else begin
                        beat_cnt <= beat_cnt;
                    end
                end
                FLUSH: begin
                    if (phase == flush_last_s) begin
                        state                 <= OUT;
                        phase                 <= {PH_W{1'b0}};
                        sa_cell_output_en_pre <= 1'b1;
                        last_en               <= (out_last_idx_s == {PH_W{1'b0}});
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                OUT: begin
                    if (phase == out_last_idx_s) begin
                        state                 <= DRAIN;
                        phase                 <= {PH_W{1'b0}};
                        sa_cell_output_en_pre <= 1'b0;
                        last_en               <= 1'b0;
                    end else begin
                        phase   <= phase + PH_W'(1);
                        last_en <= ((phase + PH_W'(1)) == out_last_idx_s);
                    end
                end
                DRAIN: begin
                    if (phase == PH_W'(OUT_LAT - 1)) begin
                        state <= DONE;
                        phase <= {PH_W{1'b0}};
                        done  <= 1'b1;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                DONE: begin
                    state              <= IDLE;
                    busy               <= 1'b0;
                    sa_mult_array_mode <= 1'b0;
                end
                default: begin
                    state                 <= IDLE;
                    busy                  <= 1'b0;
                    in_ready              <= 1'b0;
                    sa_reset              <= 1'b1;
                    sa_cell_output_en_pre <= 1'b0;
                    sa_mode_init          <= 4'd0;
                    sa_mult_array_mode    <= 1'b0;
                    last_en               <= 1'b0;
                end
            endcase
        end
    end

    // Output tagging: enables (and the last-row flag) are delayed by the array
    // output latency; the row index advances per valid and rewinds after the last.
    always_ff @(posedge clk) begin
        if (reset) begin
            ov_pipe   <= {OUT_LAT{1'b0}};
            last_pipe <= {OUT_LAT{1'b0}};
            out_row   <= {ROW_W{1'b0}};
        end else begin
            ov_pipe[0]   <= sa_cell_output_en_pre;
            last_pipe[0] <= last_en;
            for (int i = 1; i < OUT_LAT; i++) begin
                ov_pipe[i]   <= ov_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            if (out_valid) begin
                out_row <= out_last ? {ROW_W{1'b0}} : out_row + ROW_W'(1);
            end else begin
                out_row <= out_row;
            end
        end
    end

endmodule
